// File: rtl/output_deskew_pkg.sv
// Shared sizing defaults for the systolic-array output path (deskew and input parser).
// Mode encoding of the deskew block lives here so both sides agree on it.
package output_deskew_pkg;

    localparam int FULL_SIZE_DEF  = 8;
    localparam int HALF_SIZE_DEF  = 4;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    // Width of one lane slice inside a packed row.
    localparam int LANE_W = DATA_WIDTH_DEF;

    typedef enum logic {
        MODE_FULL = 1'b0,
        MODE_TILE = 1'b1
    } mode_e;

endpackage

// File: rtl/output_deskew_lane.sv
// lane_delay: enable-gated shift register of `depth` stages with a selectable tap.
// tap = 0 is a combinational pass-through; tap = k returns the k-th stage.
module lane_delay
    import output_deskew_pkg::*;
#(
    parameter int depth      = 1,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SEL_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [SEL_W-1:0]      tap,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [depth-1:0][DATA_WIDTH-1:0] sr_r;
    logic [DATA_WIDTH-1:0]            dout_s;

    // Shift stages advance only on enabled cycles; unused stages keep shifting when bypassed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r <= '0;
        end else if (enable) begin
            sr_r[0] <= din;
            for (int k = 1; k < depth; k++) begin
                sr_r[k] <= sr_r[k-1];
            end
        end
    end

    // Tap multiplexer; out-of-range taps fall back to the live input.
    always_comb begin
        dout_s = din;
        for (int k = 1; k <= depth; k++) begin
            if (tap == SEL_W'(k)) begin
                dout_s = sr_r[k-1];
            end else begin
                dout_s = dout_s;
            end
        end
    end

    assign dout = dout_s;

endmodule

// File: rtl/output_deskew.sv
// Realigns skewed systolic-array rows (full array or two half tiles) and buffers
// them in a small credit-protected FIFO with a registered head.
module output_deskew
    import output_deskew_pkg::*;
#(
    parameter int Full_Size  = FULL_SIZE_DEF,
    parameter int Half_Size  = HALF_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            tile,
    input  logic                            in_valid,
    input  logic [Full_Size*DATA_WIDTH-1:0] in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [Full_Size*DATA_WIDTH-1:0] out_data,
    output logic                            busy,
    output logic                            err
);

    localparam int ROW_W  = Full_Size * DATA_WIDTH;
    localparam int SEL_W  = $clog2(Full_Size);
    localparam int VP_LEN = Full_Size - 1;
    localparam int INF_W  = $clog2(VP_LEN + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    // Valid-pipeline stages that exist in tile mode.
    localparam logic [VP_LEN-1:0] HALF_MASK = VP_LEN'((64'd1 << (Half_Size - 1)) - 64'd1);

    mode_e                            mode_r;
    logic [VP_LEN-1:0]                vpipe_r;
    logic [VP_LEN-1:0]                vpipe_nxt_s;
    logic [INF_W-1:0]                 inflight_s;
    logic [31:0]                      used_s;
    logic                             in_ready_s;
    logic                             busy_s;
    logic                             accept_s;
    logic                             tap_valid_s;
    logic                             wr_s;
    logic                             rd_s;
    logic [ROW_W-1:0]                 aligned_s;
    logic [FIFO_DEPTH-1:0][ROW_W-1:0] mem_r;
    logic [PTR_W-1:0]                 wr_ptr_r;
    logic [PTR_W-1:0]                 rd_ptr_r;
    logic [PTR_W-1:0]                 head_idx_s;
    logic [CNT_W-1:0]                 fifo_cnt_r;
    logic [CNT_W-1:0]                 cnt_nxt_s;
    logic [ROW_W-1:0]                 head_data_s;
    logic                             out_valid_r;
    logic [ROW_W-1:0]                 out_data_r;
    logic                             err_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Per-lane deskew; lane Full_Size-1 never needs delay, and upper-half lanes
    // happen to need the same delay in both modes.
    for (genvar i = 0; i < Full_Size; i++) begin : g_lane
        localparam int LONG_D  = Full_Size - 1 - i;
        localparam int SHORT_D = Half_Size - 1 - (i % Half_Size);
        if (LONG_D == 0) begin : g_pass
            assign aligned_s[i*DATA_WIDTH +: DATA_WIDTH] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_dly
            logic [SEL_W-1:0] tap_s;
            assign tap_s = (mode_r == MODE_TILE) ? SEL_W'(SHORT_D) : SEL_W'(LONG_D);
            lane_delay #(
                .depth      (LONG_D),
                .DATA_WIDTH (DATA_WIDTH),
                .SEL_W      (SEL_W)
            ) u_lane_delay (
                .clk    (clk),
                .rst    (rst),
                .enable (enable),
                .tap    (tap_s),
                .din    (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
                .dout   (aligned_s[i*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

    // Credit accounting, acceptance and valid-pipeline next state.
    always_comb begin
        inflight_s = '0;
        for (int k = 0; k < VP_LEN; k++) begin
            inflight_s = inflight_s + INF_W'(vpipe_r[k]);
        end
        used_s     = 32'(fifo_cnt_r) + 32'(inflight_s);
        in_ready_s = (used_s < 32'(FIFO_DEPTH));
        busy_s     = (inflight_s != '0);
        accept_s   = in_valid & in_ready_s & enable;
        if (mode_r == MODE_TILE) begin
            vpipe_nxt_s = {vpipe_r[VP_LEN-2:0], accept_s} & HALF_MASK;
            tap_valid_s = vpipe_r[Half_Size-2];
        end else begin
            vpipe_nxt_s = {vpipe_r[VP_LEN-2:0], accept_s};
            tap_valid_s = vpipe_r[Full_Size-2];
        end
    end

    // FIFO next state; the head register is fed from the write data when the row
    // being written becomes the head in the same cycle.
    always_comb begin
        wr_s       = enable & tap_valid_s;
        rd_s       = out_valid_r & out_ready;
        cnt_nxt_s  = fifo_cnt_r + CNT_W'(wr_s) - CNT_W'(rd_s);
        head_idx_s = rd_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        if (wr_s && (wr_ptr_r == head_idx_s)) begin
            head_data_s = aligned_s;
        end else begin
            head_data_s = mem_r[head_idx_s];
        end
    end

    // Valid pipeline, mode register and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpipe_r <= '0;
            mode_r  <= MODE_FULL;
            err_r   <= 1'b0;
        end else begin
            if (enable) begin
                vpipe_r <= vpipe_nxt_s;
            end
            if (!busy_s && !in_valid) begin
                mode_r <= mode_e'(tile);
            end
            if (in_valid && enable && !in_ready_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // FIFO storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= aligned_s;
        end
    end

    // FIFO pointers, count and registered head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            fifo_cnt_r  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            fifo_cnt_r  <= cnt_nxt_s;
            out_valid_r <= (cnt_nxt_s != '0);
            if (cnt_nxt_s != '0) begin
                out_data_r <= head_data_s;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = busy_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign err       = err_r;

endmodule
